slv_regbank: RTL and testbench
==============================

SLV_REGBANK -- requirements
Module: slv_regbank

Interface
REQ-001 Parameter BAR_IDX, default 0: index of the slv_bar_i bit that selects this bank (0..6).
REQ-002 Parameter NUM_CTRL, default 4: number of 16-bit RW control registers (1..16).
REQ-003 Parameter ADDR_W, default 9: number of word-address bits decoded, taken from slv_adr_i[ADDR_W:1]; upper bits are ignored (aliasing).
REQ-004 Parameter ID_VALUE, default 16'h8010: read-only identification constant.
REQ-005 clk_125  input  1  system clock; all logic rises on this edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 slv_bar_i  input  7  one-hot BAR hit from the TLP engine.
REQ-008 slv_ce_i  input  1  access strobe, one cycle per 16-bit access.
REQ-009 slv_we_i  input  1  1 = write, 0 = read; qualified by slv_ce_i.
REQ-010 slv_adr_i  input  19 ([19:1])  16-bit word address.
REQ-011 slv_dat_i  input  16  write data.
REQ-012 slv_sel_i  input  2  byte enables; [0] = bits 7:0, [1] = bits 15:8.
REQ-013 slv_dat_o  output  16  read data; zero whenever slv_bar_i[BAR_IDX] = 0, for wired-OR muxing.
REQ-014 ctrl_o  output  NUM_CTRL*16  control registers concatenated; reg k occupies bits 16k+15:16k.
REQ-015 evt_i  input  16  event pulses, one bit per status flag.
REQ-016 irq_o  output  1  registered interrupt level.

Function
REQ-017 Access occurs only in cycles where slv_ce_i = 1 and slv_bar_i[BAR_IDX] = 1; any other slv_* activity has no effect.
REQ-018 Word map (A = slv_adr_i[ADDR_W:1]):
- A 0..NUM_CTRL-1: CTRL[A], RW.
- 0x10: STATUS, W1C.
- 0x11: IRQ_EN, RW.
- 0x12: CNT_LO, RO.
- 0x13: CNT_HI_SNAP, RO.
- 0x14: ID, RO.
- All other addresses: read 0, writes ignored.
REQ-019 Writes are byte-granular: only bytes whose slv_sel_i bit is 1 are affected; slv_sel_i = 0 causes no change.
REQ-020 Writes to CTRL and IRQ_EN take effect on the access edge; ctrl_o reflects the new value in the next cycle.
REQ-021 STATUS bit n sets on any cycle with evt_i[n] = 1, and clears on a write with slv_dat_i[n] = 1 and the covering sel bit set.
REQ-022 When set and clear hit the same STATUS bit in the same cycle, set wins and the bit ends at 1.
REQ-023 CNT is a 32-bit free-running counter, incremented every cycle from reset; it wraps from FFFF_FFFF to 0000_0000.
REQ-024 A read of CNT_LO returns CNT[15:0] and, on the same edge, captures CNT[31:16] into a 16-bit snapshot register.
REQ-025 A read of CNT_HI_SNAP returns the snapshot, so the LO-then-HI read pair is atomic; reading HI alone returns the last snapshot (0 after reset).
REQ-026 Read latency is 1 cycle: data is registered on the access edge and held internally until the next read access; writes do not alter the held data.
REQ-027 slv_dat_o = held data AND {16{slv_bar_i[BAR_IDX]}}; this gating is combinational.
REQ-028 irq_o is registered: irq_o <= |(STATUS & IRQ_EN), giving 1 cycle of latency after a STATUS or IRQ_EN change.
REQ-029 W1C writes and RW writes have no side effects on other registers; reads have no side effects except REQ-024.

Reset
REQ-030 While rstn = 0, independent of the clock: CTRL, STATUS, IRQ_EN, CNT, snapshot, held read data and irq_o are all 0; the slv_dat_o gating still applies.
REQ-031 Reset asserted mid-operation aborts any access in flight; the first access accepted after rstn deasserts behaves normally.

Verification
REQ-032 Write A=1 data=16'hA55A with sel=2'b01 after reset -> ctrl_o[31:16] = 16'h005A; a later read of A=1 returns 16'h005A one cycle later.
REQ-033 Pulse evt_i[3]; IRQ_EN=16'h0008 -> STATUS = 16'h0008 and irq_o = 1; write 16'h0008 to 0x10 with evt_i[3] = 0 -> STATUS = 0 and irq_o = 0 the next cycle.
REQ-034 Write 16'h0008 to 0x10 in the same cycle as evt_i[3] = 1 -> STATUS[3] stays 1.
REQ-035 Force CNT = 32'h0000_FFFF, read 0x12 then 0x13 -> returns 16'hFFFF then 16'h0000 (the snapshot), not 16'h0001.
REQ-036 Read 0x14 with slv_bar_i[BAR_IDX] = 1 -> 16'h8010; drop the bar bit -> slv_dat_o = 0 the same cycle; an access with slv_ce_i = 1 but another BAR bit set -> no register change.

Source files
------------

// File: rtl/slv_regbank.sv
// slv_regbank: BAR-decoded 16-bit slave register bank with control, W1C status, IRQ, counter and ID
module slv_regbank #(
   parameter int          BAR_IDX  = 0,
   parameter int          NUM_CTRL = 4,
   parameter int          ADDR_W   = 9,
   parameter logic [15:0] ID_VALUE = 16'h8010
) (
   input  logic                     clk_125,
   input  logic                     rstn,
   input  logic [6:0]               slv_bar_i,
   input  logic                     slv_ce_i,
   input  logic                     slv_we_i,
   input  logic [19:1]              slv_adr_i,
   input  logic [15:0]              slv_dat_i,
   input  logic [1:0]               slv_sel_i,
   output logic [15:0]              slv_dat_o,
   output logic [NUM_CTRL*16-1:0]   ctrl_o,
   input  logic [15:0]              evt_i,
   output logic                     irq_o
);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'('h10);
   localparam logic [ADDR_W-1:0] A_IRQ_EN = ADDR_W'('h11);
   localparam logic [ADDR_W-1:0] A_CNT_LO = ADDR_W'('h12);
   localparam logic [ADDR_W-1:0] A_CNT_HI = ADDR_W'('h13);
   localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'('h14);
   logic              wr, rd, unused_bits;
   logic [ADDR_W-1:0] a;
   logic [15:0]       bmask, rd_mux, status, irq_en, snap, rd_q;
   logic [31:0]       cnt;
   assign unused_bits = ^{slv_adr_i[19:ADDR_W+1], slv_bar_i};
   assign a         = slv_adr_i[ADDR_W:1];
   assign wr        = slv_ce_i & slv_bar_i[BAR_IDX] & slv_we_i;
   assign rd        = slv_ce_i & slv_bar_i[BAR_IDX] & ~slv_we_i;
   assign bmask     = {{8{slv_sel_i[1]}}, {8{slv_sel_i[0]}}};
   assign slv_dat_o = rd_q & {16{slv_bar_i[BAR_IDX]}};
   // address decode of the value a read access would return; unmapped words read zero
   always_comb begin
      rd_mux = '0;
      for (int k = 0; k < NUM_CTRL; k++)
         if (a == ADDR_W'(k)) rd_mux = ctrl_o[16*k +: 16];
      if (a == A_STATUS) rd_mux = status;
      if (a == A_IRQ_EN) rd_mux = irq_en;
      if (a == A_CNT_LO) rd_mux = cnt[15:0];
      if (a == A_CNT_HI) rd_mux = snap;
      if (a == A_ID)     rd_mux = ID_VALUE;
   end
   // byte-granular writes into the control registers
   always_ff @(posedge clk_125 or negedge rstn)
      if (!rstn) ctrl_o <= '0;
      else if (wr)
         for (int k = 0; k < NUM_CTRL; k++)
            if (a == ADDR_W'(k)) ctrl_o[16*k +: 16] <= (ctrl_o[16*k +: 16] & ~bmask) | (slv_dat_i & bmask);
   // sticky status: events set, W1C write clears, set dominates a same-cycle clear
   always_ff @(posedge clk_125 or negedge rstn)
      if (!rstn) status <= '0;
      else status <= (status & ~((wr && a == A_STATUS) ? slv_dat_i & bmask : 16'h0)) | evt_i;
   // interrupt enable mask, byte-granular
   always_ff @(posedge clk_125 or negedge rstn)
      if (!rstn) irq_en <= '0;
      else if (wr && a == A_IRQ_EN) irq_en <= (irq_en & ~bmask) | (slv_dat_i & bmask);
   // free-running cycle counter
   always_ff @(posedge clk_125 or negedge rstn)
      if (!rstn) cnt <= '0;
      else cnt <= cnt + 32'd1;
   // read data is held until the next read; a CNT_LO read freezes the upper half for a later HI read
   always_ff @(posedge clk_125 or negedge rstn)
      if (!rstn) begin
         rd_q <= '0;
         snap <= '0;
      end else if (rd) begin
         rd_q <= rd_mux;
         if (a == A_CNT_LO) snap <= cnt[31:16];
      end
   // interrupt level, one cycle behind the status/enable registers
   always_ff @(posedge clk_125 or negedge rstn)
      if (!rstn) irq_o <= 1'b0;
      else irq_o <= |(status & irq_en);
endmodule

// File: tb/tb_slv_regbank.sv
// tb_slv_regbank: directed stimulus against a behavioural register-bank model with per-cycle output compare
module tb_slv_regbank;
   localparam int N = 4;
   logic            clk_125 = 1'b0, rstn = 1'b0;
   logic [6:0]      bar;
   logic            ce, we;
   logic [19:1]     adr;
   logic [15:0]     dat, evt, dat_o, d;
   logic [1:0]      sel;
   logic [N*16-1:0] ctrl_o;
   logic            irq_o;
   int              errors = 0, checks = 0, g;
   logic [15:0]     m_ctrl [16];
   logic [15:0]     m_status, m_en, m_snap, m_rd, mm;
   logic [31:0]     m_cnt;
   logic            m_irq;
   int              ma;

   always #4 clk_125 = ~clk_125;

   slv_regbank dut (
      .clk_125(clk_125), .rstn(rstn), .slv_bar_i(bar), .slv_ce_i(ce), .slv_we_i(we),
      .slv_adr_i(adr), .slv_dat_i(dat), .slv_sel_i(sel), .slv_dat_o(dat_o),
      .ctrl_o(ctrl_o), .evt_i(evt), .irq_o(irq_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_read(input int a);
      if (a < N) return m_ctrl[a];
      case (a)
         'h10: return m_status;
         'h11: return m_en;
         'h12: return m_cnt[15:0];
         'h13: return m_snap;
         'h14: return 16'h8010;
         default: return 16'h0;
      endcase
   endfunction

   // behavioural model: register map applied to whole words, values seen before the edge
   always @(posedge clk_125 or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 16; i++) m_ctrl[i] = '0;
         m_status = '0; m_en = '0; m_snap = '0; m_rd = '0; m_cnt = '0; m_irq = 1'b0;
      end else begin
         ma = int'(adr) % 512;
         mm = {{8{sel[1]}}, {8{sel[0]}}};
         m_irq = (m_status & m_en) != 16'h0;
         if (ce && bar[0]) begin
            if (!we) begin
               m_rd = m_read(ma);
               if (ma == 'h12) m_snap = m_cnt[31:16];
            end else if (ma < N) m_ctrl[ma] = (m_ctrl[ma] & ~mm) | (dat & mm);
            else if (ma == 'h11) m_en = (m_en & ~mm) | (dat & mm);
            else if (ma == 'h10) m_status = m_status & ~(dat & mm);
         end
         m_status = m_status | evt;
         m_cnt = m_cnt + 1;
      end
   end

   // compare outputs against the model just after every edge
   always @(posedge clk_125) begin
      #1;
      for (int k = 0; k < N; k++) chk("ctrl_o", 32'(ctrl_o[16*k +: 16]), 32'(m_ctrl[k]));
      chk("irq_o", 32'(irq_o), 32'(m_irq));
      chk("slv_dat_o", 32'(dat_o), 32'(m_rd & {16{bar[0]}}));
   end

   task automatic wr(input logic [19:1] a, input logic [15:0] v, input logic [1:0] s);
      ce = 1'b1; we = 1'b1; adr = a; dat = v; sel = s;
      @(negedge clk_125);
      ce = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [19:1] a, output logic [15:0] v);
      ce = 1'b1; we = 1'b0; adr = a;
      @(negedge clk_125);
      ce = 1'b0;
      v = dat_o;
   endtask

   initial begin
      bar = 7'b0000001; ce = 0; we = 0; adr = '0; dat = '0; sel = '0; evt = '0;
      repeat (3) @(negedge clk_125);
      chk("reset ctrl_o", 32'(ctrl_o), 32'h0);
      chk("reset irq_o", 32'(irq_o), 32'h0);
      chk("reset dat_o", 32'(dat_o), 32'h0);
      rstn = 1'b1;
      @(negedge clk_125);
      wr(19'h1, 16'hA55A, 2'b01);
      chk("ctrl1 low byte", 32'(ctrl_o[31:16]), 32'h005A);
      rd(19'h1, d);  chk("read ctrl1", 32'(d), 32'h005A);
      wr(19'h2, 16'h1234, 2'b00);
      chk("sel none", 32'(ctrl_o[47:32]), 32'h0000);
      wr(19'h2, 16'h1234, 2'b10);
      chk("sel high", 32'(ctrl_o[47:32]), 32'h1200);
      wr(19'h203, 16'hBEEF, 2'b11);
      chk("alias ctrl3", 32'(ctrl_o[63:48]), 32'hBEEF);
      wr(19'h20, 16'hFFFF, 2'b11);
      rd(19'h20, d); chk("unmapped read", 32'(d), 32'h0);
      rd(19'h13, d); chk("hi snap after reset", 32'(d), 32'h0);
      wr(19'h11, 16'h0008, 2'b11);
      rd(19'h11, d); chk("irq_en read", 32'(d), 32'h0008);
      evt = 16'h0008;
      @(negedge clk_125);
      evt = 16'h0;
      @(negedge clk_125);
      chk("irq set", 32'(irq_o), 32'h1);
      rd(19'h10, d); chk("status set", 32'(d), 32'h0008);
      wr(19'h10, 16'h0008, 2'b11);
      chk("irq lag", 32'(irq_o), 32'h1);
      @(negedge clk_125);
      chk("irq clear", 32'(irq_o), 32'h0);
      rd(19'h10, d); chk("status clear", 32'(d), 32'h0);
      evt = 16'h0008;
      wr(19'h10, 16'h0008, 2'b11);
      evt = 16'h0;
      rd(19'h10, d); chk("set wins", 32'(d), 32'h0008);
      wr(19'h10, 16'h0008, 2'b10);
      rd(19'h10, d); chk("w1c wrong byte", 32'(d), 32'h0008);
      wr(19'h10, 16'h0008, 2'b01);
      rd(19'h10, d); chk("w1c right byte", 32'(d), 32'h0);
      rd(19'h14, d); chk("id", 32'(d), 32'h8010);
      bar = 7'b0;
      #1 chk("bar gate", 32'(dat_o), 32'h0);
      bar = 7'b0000010;
      wr(19'h0, 16'hFFFF, 2'b11);
      bar = 7'b0000001;
      #1;
      chk("other bar no write", 32'(ctrl_o[15:0]), 32'h0);
      chk("other bar held data", 32'(dat_o), 32'h8010);
      @(negedge clk_125);
      g = 0;
      while (m_cnt != 32'h0000FFFF && g < 70000) begin
         @(negedge clk_125);
         g++;
      end
      chk("cnt reach timeout", 32'(g < 70000), 32'h1);
      rd(19'h12, d); chk("cnt lo", 32'(d), 32'hFFFF);
      rd(19'h13, d); chk("cnt hi snap", 32'(d), 32'h0000);
      ce = 1'b1; we = 1'b1; adr = 19'h0; dat = 16'h1111; sel = 2'b11;
      #2 rstn = 1'b0;
      @(negedge clk_125);
      ce = 1'b0; we = 1'b0;
      chk("mid reset ctrl", 32'(ctrl_o), 32'h0);
      chk("mid reset dat", 32'(dat_o), 32'h0);
      chk("mid reset irq", 32'(irq_o), 32'h0);
      rstn = 1'b1;
      wr(19'h0, 16'h4321, 2'b11);
      chk("post reset write", 32'(ctrl_o[15:0]), 32'h4321);
      rd(19'h0, d); chk("post reset read", 32'(d), 32'h4321);
      repeat (2) @(negedge clk_125);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
